// File: rtl/temp_avg_sequencer.sv
// Multi-cycle sensor averaging: snapshot, serial sum/count scan, restoring divide, registered display outputs.
// Define AVG_ROUND_EN to round the average half-up instead of truncating.
module temp_avg_sequencer #(
    parameter int S_NR       = 8,
    parameter int TEMP_WIDTH = 5,
    parameter int T_MIN      = 19,
    parameter int T_MAX      = 26
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [S_NR*TEMP_WIDTH-1:0]   value,
    input  logic [S_NR-1:0]              enable,
    output logic                         busy,
    output logic                         done,
    output logic [TEMP_WIDTH-1:0]        avg,
    output logic [T_MAX-T_MIN:0]         led_output,
    output logic                         alert
);
    localparam int W     = TEMP_WIDTH;
    localparam int DW    = 2 * W;
    localparam int LED_W = T_MAX - T_MIN + 1;
    localparam int IDX_W = (S_NR > 1) ? $clog2(S_NR) : 1;
    localparam int CNT_W = $clog2(DW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(S_NR - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DW - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DIV, RESULT} state_t;

    state_t                state;
    logic [S_NR*W-1:0]     val_q;
    logic [S_NR-1:0]       en_q;
    logic [IDX_W-1:0]      idx;
    logic [DW-1:0]         sum, count, quo;
    logic [DW:0]           rem;
    logic [CNT_W-1:0]      dcnt;

    logic [W-1:0]          cur;
    logic [DW-1:0]         sum_nxt, cnt_nxt, dividend;
    logic [DW:0]           rem_sh, rem_sub;
    logic                  ge;
    logic [W-1:0]          avg_q;
    logic [LED_W-1:0]      led_nxt;
    logic                  out_of_range;

    assign cur     = val_q[idx*W +: W];
    assign sum_nxt = sum + (en_q[idx] ? DW'(cur) : '0);
    assign cnt_nxt = count + DW'(en_q[idx]);
`ifdef AVG_ROUND_EN
    assign dividend = sum_nxt + (cnt_nxt >> 1);
`else
    assign dividend = sum_nxt;
`endif

    // Shift in the next dividend bit; a set top bit already guarantees rem_sh >= divisor.
    assign rem_sh  = {rem[DW-1:0], quo[DW-1]};
    assign rem_sub = rem_sh - {1'b0, count};
    assign ge      = rem[DW] | (rem_sh >= {1'b0, count});

    assign avg_q        = quo[W-1:0];
    assign out_of_range = (int'(avg_q) < T_MIN) || (int'(avg_q) > T_MAX);

    // Thermometer code: bit i lights once avg reaches T_MIN+i, saturating both ends.
    for (genvar i = 0; i < LED_W; i++) begin : g_led
        assign led_nxt[i] = (int'(avg_q) >= T_MIN + i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            val_q      <= '0;
            en_q       <= '0;
            idx        <= '0;
            sum        <= '0;
            count      <= '0;
            quo        <= '0;
            rem        <= '0;
            dcnt       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            avg        <= '0;
            led_output <= '0;
            alert      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        val_q <= value;
                        en_q  <= enable;
                        sum   <= '0;
                        count <= '0;
                        idx   <= '0;
                        quo   <= '0;
                        rem   <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    sum   <= sum_nxt;
                    count <= cnt_nxt;
                    idx   <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        if (cnt_nxt == '0) begin
                            state <= RESULT;
                        end else begin
                            quo   <= dividend;
                            rem   <= '0;
                            dcnt  <= '0;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem  <= ge ? rem_sub : rem_sh;
                    quo  <= {quo[DW-2:0], ge};
                    dcnt <= dcnt + CNT_W'(1);
                    if (dcnt == LAST_BIT) state <= RESULT;
                end
                RESULT: begin
                    if (count == '0) begin
                        avg        <= '0;
                        led_output <= '0;
                        alert      <= 1'b1;
                    end else begin
                        avg        <= avg_q;
                        led_output <= led_nxt;
                        alert      <= out_of_range;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_temp_avg_sequencer.sv
// Scoreboard bench for temp_avg_sequencer: driver pushes hand-computed results, monitor checks on done.
module tb_temp_avg_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [39:0] value = '0;
    logic [7:0]  enable = '0;
    logic        busy, done, alert;
    logic [4:0]  avg;
    logic [7:0]  led_output;

    temp_avg_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .enable(enable),
        .busy(busy), .done(done), .avg(avg), .led_output(led_output), .alert(alert)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int avg; int led; int alert; int lat; int t0;} exp_t;
    exp_t sbq[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [39:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [39:0] p;
        p[4:0]   = 5'(a0); p[9:5]   = 5'(a1); p[14:10] = 5'(a2); p[19:15] = 5'(a3);
        p[24:20] = 5'(a4); p[29:25] = 5'(a5); p[34:30] = 5'(a6); p[39:35] = 5'(a7);
        return p;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("avg", int'(avg), e.avg);
                check("led_output", int'(led_output), e.led);
                check("alert", int'(alert), e.alert);
                check("latency", cyc - e.t0, e.lat);
            end
        end
    end

    // glitch >= 0: at that negedge after edge 0, pulse start and scramble value.
    task automatic run(input logic [39:0] v, input logic [7:0] e, input int ea,
                       input int el, input int eal, input int lat, input int glitch);
        exp_t x;
        bit seen;
        @(negedge clk);
        value = v; enable = e; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x.avg = ea; x.led = el; x.alert = eal; x.lat = lat; x.t0 = cyc;
        sbq.push_back(x);
        check("busy_rise", int'(busy), 1);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == glitch) begin
                start = 1'b1; value = ~v; enable = ~e;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1;
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_pulse_width", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_avg", int'(avg), 0);
        check("rst_led", int'(led_output), 0);
        check("rst_alert", int'(alert), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("busy_after_release", int'(busy), 0);

        run(pack8(22,22,22,22,22,22,22,22), 8'hFF, 22, 8'h0F, 0, 19, -1);
        run(pack8(22,22,22,22,22,22,22,22), 8'h00, 0, 8'h00, 1, 9, -1);
`ifdef AVG_ROUND_EN
        run(pack8(20,21,31,31,31,31,31,31), 8'h03, 21, 8'h07, 0, 19, -1);
        run(pack8(0,20,31,23,0,25,31,0), 8'h2A, 23, 8'h1F, 0, 19, -1);
`else
        run(pack8(20,21,31,31,31,31,31,31), 8'h03, 20, 8'h03, 0, 19, -1);
        run(pack8(0,20,31,23,0,25,31,0), 8'h2A, 22, 8'h0F, 0, 19, -1);
`endif
        run(pack8(0,0,0,31,0,0,0,0), 8'h08, 31, 8'hFF, 1, 19, -1);
        run(pack8(10,0,0,0,0,0,0,0), 8'h01, 10, 8'h00, 1, 19, -1);
        run(pack8(0,0,0,0,0,0,0,26), 8'h80, 26, 8'hFF, 0, 19, -1);
        run(pack8(19,19,19,19,0,0,0,0), 8'h0F, 19, 8'h01, 0, 19, -1);
        run(pack8(18,18,0,0,0,0,0,0), 8'h03, 18, 8'h00, 1, 19, -1);

        // start and input changes during DIV must not restart or disturb the run
        run(pack8(24,24,24,24,24,24,24,24), 8'hFF, 24, 8'h3F, 0, 19, 11);
        repeat (25) @(negedge clk);
        check("no_queued_start", int'(busy), 0);

        // Reset mid-DIV aborts with no partial result
        @(negedge clk);
        value = pack8(30,30,30,30,30,30,30,30); enable = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_avg", int'(avg), 0);
        check("abort_led", int'(led_output), 0);
        check("abort_alert", int'(alert), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(pack8(21,21,21,21,21,21,21,21), 8'hFF, 21, 8'h07, 0, 19, -1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
